fpr_wb_scheduler: RTL and testbench
===================================

# fpr_wb_scheduler

Write-port scheduler and scoreboard for the 32-entry floating-point register file. It shares the file's single write port between the FPU result path and the FP load path using round-robin arbitration and drives the registered write strobe, address and data into the file. It also keeps one busy bit per register so the issue stage stalls on RAW and WAW hazards against pending writes.

## Interface
- NREGS, 32, number of FP registers; busy vector width
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  issue stage presents an FP instruction
- issue_wr  in  1  instruction will write issue_rd
- issue_rs, issue_rt, issue_rd  in  AW each  source and destination register numbers
- issue_stall  out  1  combinational: hold issue this cycle
- fpu_req  in  1  FPU result ready for writeback
- fpu_rd  in  AW  FPU destination register
- fpu_data  in  DW  FPU result
- fpu_gnt  out  1  combinational: FPU write accepted this cycle
- mem_req  in  1  load data ready for writeback
- mem_rd  in  AW  load destination register
- mem_data  in  DW  load data
- mem_gnt  out  1  combinational: load write accepted this cycle
- rf_wr  out  1  registered write enable to the register file
- rf_waddr  out  AW  registered write address
- rf_wdata  out  DW  registered write data
- busy  out  NREGS  registered scoreboard, one bit per register

## Operation
- Hazard check: issue_stall = issue_valid & (busy[issue_rs] | busy[issue_rt] | (issue_wr & busy[issue_rd])).
- Accepted issue (issue_valid & !issue_stall & issue_wr) sets busy[issue_rd] at the clock edge.
- Arbitration: only fpu_req asserted grants FPU; only mem_req asserted grants MEM. When both are asserted, grant the requester not granted last; the last-winner flop updates on every grant. At most one gnt per cycle.
- Requesters hold req, rd and data stable until they see gnt. Deassert req the cycle after gnt unless a new result is presented.
- At the grant edge, the winner's rd/data load into rf_waddr/rf_wdata and rf_wr is set. With no grant, rf_wr = 0 and rf_waddr/rf_wdata hold their values.
- busy[rf_waddr] clears at the edge where rf_wr = 1, which is the same edge the register file captures the data.
- Set/clear collision on the same register at the same edge: set wins. The WAW stall prevents this during legal operation.
- A write to a non-busy register is still performed. busy stays 0.
- Reset (reset = 0, asynchronous): busy = 0, rf_wr = 0, rf_waddr = 0, rf_wdata = 0, last-winner = MEM so FPU wins the first tie. Requests in flight are dropped. Requesters must re-present after reset.

## Timing
- Grant is combinational in request cycle N. rf_wr is high in N+1. The register file is written and busy cleared at the end of N+1. A dependent instruction unstalls in N+2.
- Throughput: one write per cycle. Under continuous contention, grants alternate FPU, MEM, FPU, ...
- Issue-to-busy: set visible the cycle after the accepted issue.
- All outputs except issue_stall, fpu_gnt and mem_gnt are registered. The gnt outputs depend only on req and the last-winner flop, not on issue inputs.

## Test plan
- Reset then idle: busy = 0, rf_wr = 0, issue_valid = 1 rs = 1 rt = 2 -> issue_stall = 0.
- Issue wr rd = 5, then issue rs = 5 -> stall asserted. fpu_req rd = 5 data = 0x3F800000 -> fpu_gnt the same cycle, rf_wr = 1 waddr = 5 wdata = 0x3F800000 next cycle, busy[5] = 0 and stall drops the cycle after.
- fpu_req and mem_req held high 4 cycles (rd 3 and 4) -> grants FPU, MEM, FPU, MEM, one per cycle, never both.
- WAW: busy[7] = 1, issue wr rd = 7 -> stall. After mem write to 7 -> issue accepted and busy[7] set again.
- Same-edge set/clear: force rf_wr to reg 9 and issue wr rd = 9 with busy[9] = 0 -> busy[9] = 1 afterwards.
- Assert reset mid-grant with busy = 0x00000F00 -> immediately busy = 0, rf_wr = 0. After release, a tie grants FPU first.

Source files
------------

// File: rtl/fpr_wb_scheduler.sv
// Write-port scheduler and busy-bit scoreboard for the FP register file.
// Round-robin shares the single write port between FPU results and FP loads.
module fpr_wb_scheduler #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [AW-1:0]    issue_rs,
    input  logic [AW-1:0]    issue_rt,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_stall,
    input  logic             fpu_req,
    input  logic [AW-1:0]    fpu_rd,
    input  logic [DW-1:0]    fpu_data,
    output logic             fpu_gnt,
    input  logic             mem_req,
    input  logic [AW-1:0]    mem_rd,
    input  logic [DW-1:0]    mem_data,
    output logic             mem_gnt,
    output logic             rf_wr,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [NREGS-1:0] busy
);

    localparam logic [0:0] LW_FPU = 1'b0;
    localparam logic [0:0] LW_MEM = 1'b1;

    logic [0:0]       last_q;
    logic [0:0]       last_d;
    logic             issue_accept;
    logic             rf_wr_d;
    logic [AW-1:0]    rf_waddr_d;
    logic [DW-1:0]    rf_wdata_d;
    logic [NREGS-1:0] busy_d;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        fpu_gnt = 1'b0;
        mem_gnt = 1'b0;
        last_d  = last_q;
        if (fpu_req && (!mem_req || (last_q == LW_MEM))) begin
            fpu_gnt = 1'b1;
            last_d  = LW_FPU;
        end else if (mem_req) begin
            mem_gnt = 1'b1;
            last_d  = LW_MEM;
        end
    end

    // Winner's destination and data are staged into the write-port registers.
    always_comb begin
        rf_wr_d    = fpu_gnt | mem_gnt;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        if (fpu_gnt) begin
            rf_waddr_d = fpu_rd;
            rf_wdata_d = fpu_data;
        end else if (mem_gnt) begin
            rf_waddr_d = mem_rd;
            rf_wdata_d = mem_data;
        end
    end

    // RAW/WAW hazard check against pending writes.
    always_comb begin
        issue_stall  = issue_valid & (busy[issue_rs] | busy[issue_rt] |
                                      (issue_wr & busy[issue_rd]));
        issue_accept = issue_valid & ~issue_stall & issue_wr;
    end

    // Clear on the write edge, then set; a same-register collision keeps it busy.
    always_comb begin
        busy_d = busy;
        if (rf_wr) begin
            busy_d[rf_waddr] = 1'b0;
        end
        if (issue_accept) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q   <= LW_MEM;
            rf_wr    <= 1'b0;
            rf_waddr <= AW'(0);
            rf_wdata <= DW'(0);
            busy     <= NREGS'(0);
        end else begin
            last_q   <= last_d;
            rf_wr    <= rf_wr_d;
            rf_waddr <= rf_waddr_d;
            rf_wdata <= rf_wdata_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_fpr_wb_scheduler.sv
// Directed bench for fpr_wb_scheduler: per-cycle comparison against a
// behavioural scoreboard model plus hand-computed spot checks.
module tb_fpr_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid, issue_wr;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        issue_stall;
    logic        fpu_req, mem_req;
    logic [4:0]  fpu_rd, mem_rd;
    logic [31:0] fpu_data, mem_data;
    logic        fpu_gnt, mem_gnt;
    logic        rf_wr;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int tests = 0;
    int fails = 0;

    fpr_wb_scheduler #(.NREGS(32), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
        .issue_stall(issue_stall),
        .fpu_req(fpu_req), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_gnt(fpu_gnt),
        .mem_req(mem_req), .mem_rd(mem_rd), .mem_data(mem_data), .mem_gnt(mem_gnt),
        .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: set of registers with a write outstanding, who won the last tie-break,
    // and the write currently on its way into the register file.
    localparam int NONE = 0;
    localparam int FPU  = 1;
    localparam int MEM  = 2;

    logic [31:0] m_pending;
    int          m_last_winner;
    logic        m_wr;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic int winner();
        if (fpu_req && mem_req) return (m_last_winner == FPU) ? MEM : FPU;
        if (fpu_req) return FPU;
        if (mem_req) return MEM;
        return NONE;
    endfunction

    function automatic logic must_stall();
        if (!issue_valid) return 1'b0;
        return m_pending[issue_rs] || m_pending[issue_rt] || (issue_wr && m_pending[issue_rd]);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pending     = '0;
            m_last_winner = MEM;
            m_wr          = 1'b0;
            m_waddr       = '0;
            m_wdata       = '0;
        end else begin
            int w;
            logic accepted;
            w = winner();
            accepted = issue_valid && issue_wr && !must_stall();
            if (m_wr) m_pending[m_waddr] = 1'b0;
            if (accepted) m_pending[issue_rd] = 1'b1;
            m_wr = (w != NONE);
            if (w == FPU) begin
                m_waddr = fpu_rd;
                m_wdata = fpu_data;
            end else if (w == MEM) begin
                m_waddr = mem_rd;
                m_wdata = mem_data;
            end
            if (w != NONE) m_last_winner = w;
        end
    end

    // Every cycle out of reset: all outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            int w;
            w = winner();
            chk("m_stall",   32'(issue_stall), 32'(must_stall()));
            chk("m_fpu_gnt", 32'(fpu_gnt),     32'(w == FPU));
            chk("m_mem_gnt", 32'(mem_gnt),     32'(w == MEM));
            chk("m_rf_wr",   32'(rf_wr),       32'(m_wr));
            chk("m_waddr",   32'(rf_waddr),    32'(m_waddr));
            chk("m_wdata",   rf_wdata,         m_wdata);
            chk("m_busy",    busy,             m_pending);
            if (fpu_gnt && mem_gnt) chk("both_gnt", 32'd1, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_issue(input logic v, input logic wr, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd);
        issue_valid = v;
        issue_wr    = wr;
        issue_rs    = rs;
        issue_rt    = rt;
        issue_rd    = rd;
    endtask

    initial begin
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        fpu_req = 1'b0; fpu_rd = '0; fpu_data = '0;
        mem_req = 1'b0; mem_rd = '0; mem_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset
        set_issue(1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
        mid();
        chk("rst_busy", busy, 32'h0);
        chk("rst_rf_wr", 32'(rf_wr), 32'd0);
        chk("idle_stall", 32'(issue_stall), 32'd0);
        tick();

        // RAW on f5 resolved by an FPU write
        set_issue(1'b1, 1'b1, 5'd1, 5'd2, 5'd5);
        mid(); chk("iss5_stall", 32'(issue_stall), 32'd0);
        tick();
        set_issue(1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
        fpu_req = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h3F800000;
        mid();
        chk("busy5_set", 32'(busy[5]), 32'd1);
        chk("raw_stall", 32'(issue_stall), 32'd1);
        chk("fpu_gnt5", 32'(fpu_gnt), 32'd1);
        tick();
        fpu_req = 1'b0;
        mid();
        chk("wr5_rf_wr", 32'(rf_wr), 32'd1);
        chk("wr5_waddr", 32'(rf_waddr), 32'd5);
        chk("wr5_wdata", rf_wdata, 32'h3F800000);
        chk("wr5_stall", 32'(issue_stall), 32'd1);
        tick();
        mid();
        chk("busy5_clr", 32'(busy[5]), 32'd0);
        chk("unstall5", 32'(issue_stall), 32'd0);
        chk("idle_rf_wr", 32'(rf_wr), 32'd0);
        tick();
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Single MEM grant so the next tie goes to FPU
        mem_req = 1'b1; mem_rd = 5'd0; mem_data = 32'h0;
        mid(); chk("mem_only", 32'(mem_gnt), 32'd1);
        tick();
        mem_req = 1'b0;

        // Continuous contention alternates FPU, MEM, FPU, MEM
        fpu_req = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h40000000;
        mem_req = 1'b1; mem_rd = 5'd4; mem_data = 32'h40400000;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("rr_fpu", 32'(fpu_gnt), 32'(i % 2 == 0));
            chk("rr_mem", 32'(mem_gnt), 32'(i % 2 == 1));
            tick();
        end
        fpu_req = 1'b0; mem_req = 1'b0;
        mid();
        chk("rr_last_waddr", 32'(rf_waddr), 32'd4);
        chk("rr_last_wdata", rf_wdata, 32'h40400000);
        tick();

        // WAW on f7 resolved by a load
        set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
        mid(); chk("iss7_stall", 32'(issue_stall), 32'd0);
        tick();
        mem_req = 1'b1; mem_rd = 5'd7; mem_data = 32'hC0000000;
        mid();
        chk("busy7_set", 32'(busy[7]), 32'd1);
        chk("waw_stall", 32'(issue_stall), 32'd1);
        chk("mem_gnt7", 32'(mem_gnt), 32'd1);
        tick();
        mem_req = 1'b0;
        mid();
        chk("wr7_waddr", 32'(rf_waddr), 32'd7);
        chk("wr7_stall", 32'(issue_stall), 32'd1);
        tick();
        mid();
        chk("busy7_clr", 32'(busy[7]), 32'd0);
        chk("waw_accept", 32'(issue_stall), 32'd0);
        tick();
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        mid(); chk("busy7_reset", 32'(busy[7]), 32'd1);
        tick();

        // Same-edge set/clear on f9: set wins
        fpu_req = 1'b1; fpu_rd = 5'd9; fpu_data = 32'h12345678;
        mid(); chk("fpu_gnt9", 32'(fpu_gnt), 32'd1);
        tick();
        fpu_req = 1'b0;
        set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
        mid();
        chk("wr9_rf_wr", 32'(rf_wr), 32'd1);
        chk("wr9_waddr", 32'(rf_waddr), 32'd9);
        chk("iss9_stall", 32'(issue_stall), 32'd0);
        tick();
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        mid(); chk("busy9_set_wins", 32'(busy[9]), 32'd1);
        tick();

        // Retire f7, then mark f8, f10, f11 busy
        fpu_req = 1'b1; fpu_rd = 5'd7; fpu_data = 32'h0;
        tick();
        fpu_req = 1'b0;
        tick();
        for (int r = 8; r <= 11; r++) begin
            if (r != 9) begin
                set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'(r));
                mid(); chk("iss_f8_11", 32'(issue_stall), 32'd0);
                tick();
            end
        end
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Asynchronous reset in the middle of a grant cycle
        fpu_req = 1'b1; fpu_rd = 5'd8; fpu_data = 32'hDEADBEEF;
        mid();
        chk("busy_f00", busy, 32'h00000F00);
        chk("pre_rst_gnt", 32'(fpu_gnt), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 32'h0);
        chk("arst_rf_wr", 32'(rf_wr), 32'd0);
        chk("arst_waddr", 32'(rf_waddr), 32'd0);
        chk("arst_wdata", rf_wdata, 32'h0);
        fpu_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // First tie after reset goes to FPU, then MEM
        fpu_req = 1'b1; fpu_rd = 5'd1; fpu_data = 32'h11111111;
        mem_req = 1'b1; mem_rd = 5'd2; mem_data = 32'h22222222;
        mid();
        chk("post_rst_fpu", 32'(fpu_gnt), 32'd1);
        chk("post_rst_mem", 32'(mem_gnt), 32'd0);
        tick();
        mid();
        chk("post_rst_mem2", 32'(mem_gnt), 32'd1);
        tick();
        fpu_req = 1'b0; mem_req = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
